// File: rtl/fft_pkg.sv
// Shared definitions for the streaming FFT datapath.
// Holds the default sample width and the pair-phase type used by the butterfly.
package fft_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;

    typedef enum logic {
        PH_A = 1'b0,
        PH_B = 1'b1
    } pairPhase_t;

endpackage

// File: rtl/radix2_addsub.sv
// Combinational sum/difference core of the radix-2 butterfly.
// Both operands are sign-extended by one bit first, so a+b and a-b are always exact.
module radix2_addsub
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic [DATA_WIDTH:0]   o_sum,
    output logic [DATA_WIDTH:0]   o_diff
);

    logic [DATA_WIDTH:0] w_aExt;
    logic [DATA_WIDTH:0] w_bExt;

    assign w_aExt = {i_a[DATA_WIDTH-1], i_a};
    assign w_bExt = {i_b[DATA_WIDTH-1], i_b};

    assign o_sum  = w_aExt + w_bExt;
    assign o_diff = w_aExt - w_bExt;

endmodule

// File: rtl/radix2_butterfly.sv
// Serial radix-2 DIT butterfly: consecutive accepted samples form a pair (a, b);
// the sum is emitted one cycle after b, the difference on the next enabled cycle.
// Optional feature macro: RADIX2_BUTTERFLY_LAST_EN adds the lastOut port, which
// marks the difference beat.
module radix2_butterfly
    import fft_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clkIn,
    input  logic                  rstIn,
    input  logic                  enIn,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  validIn,
    output logic                  validOut,
    output logic [DATA_WIDTH:0]   dataOut
`ifdef RADIX2_BUTTERFLY_LAST_EN
    ,
    output logic                  lastOut
`endif
);

    pairPhase_t            r_phase;
    pairPhase_t            w_phaseNext;
    logic [DATA_WIDTH-1:0] r_a;
    logic [DATA_WIDTH:0]   r_pendDiff;
    logic                  r_pendValid;
    logic                  r_validOut;
    logic [DATA_WIDTH:0]   r_dataOut;
    logic                  w_accept;
    logic                  w_acceptB;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH:0]   w_diff;

    assign w_accept  = enIn & validIn;
    assign w_acceptB = w_accept & (r_phase == PH_B);

    radix2_addsub #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_addsub (
        .i_a   (r_a),
        .i_b   (dataIn),
        .o_sum (w_sum),
        .o_diff(w_diff)
    );

    // Pair phase flips on every accepted sample and holds across gaps and disabled cycles.
    always_comb begin
        w_phaseNext = r_phase;
        if (w_accept) begin
            w_phaseNext = (r_phase == PH_A) ? PH_B : PH_A;
        end
    end

    // Phase register plus capture of the first sample of each pair.
    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            r_phase <= PH_A;
            r_a     <= '0;
        end else begin
            r_phase <= w_phaseNext;
            if (w_accept && (r_phase == PH_A)) begin
                r_a <= dataIn;
            end
        end
    end

    // Output beat: sum when b arrives, otherwise drain a pending diff; disabled cycles emit nothing.
    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            r_validOut  <= 1'b0;
            r_dataOut   <= '0;
            r_pendDiff  <= '0;
            r_pendValid <= 1'b0;
        end else if (!enIn) begin
            r_validOut <= 1'b0;
        end else if (w_acceptB) begin
            r_validOut  <= 1'b1;
            r_dataOut   <= w_sum;
            r_pendDiff  <= w_diff;
            r_pendValid <= 1'b1;
        end else if (r_pendValid) begin
            r_validOut  <= 1'b1;
            r_dataOut   <= r_pendDiff;
            r_pendValid <= 1'b0;
        end else begin
            r_validOut <= 1'b0;
        end
    end

    assign validOut = r_validOut;
    assign dataOut  = r_dataOut;

`ifdef RADIX2_BUTTERFLY_LAST_EN
    logic r_lastOut;

    // Flag is raised only on the beat that carries the drained difference.
    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            r_lastOut <= 1'b0;
        end else if (!enIn || w_acceptB) begin
            r_lastOut <= 1'b0;
        end else begin
            r_lastOut <= r_pendValid;
        end
    end

    assign lastOut = r_lastOut;
`endif

endmodule

// File: tb/tb_radix2_butterfly.sv
// Testbench for radix2_butterfly: directed pairs with exact timing checks plus a
// randomized stream checked against a sample-level reference model (sum and diff FIFOs).
module tb_radix2_butterfly;

    localparam int W = 32;

    logic           clkIn = 1'b0;
    logic           rstIn;
    logic           enIn;
    logic           validIn;
    logic [W-1:0]   dataIn;
    logic           validOut;
    logic [W:0]     dataOut;
`ifdef RADIX2_BUTTERFLY_LAST_EN
    logic           lastOut;
`endif

    int checkCount = 0;
    int failCount  = 0;
    int acceptCount = 0;

    logic [W:0]   sumQ[$];
    logic [W:0]   diffQ[$];
    logic [W-1:0] heldA = '0;
    bit           modelPhaseB = 1'b0;
    bit           edgeEnabled = 1'b0;
    logic [W:0]   lastData = '0;
    logic [W:0]   expData;
    bit           expValid;
    bit           expIsDiff;
    longint       opA;
    longint       opB;
    longint       result;

    radix2_butterfly #(
        .DATA_WIDTH(W)
    ) dut (
        .clkIn   (clkIn),
        .rstIn   (rstIn),
        .enIn    (enIn),
        .dataIn  (dataIn),
        .validIn (validIn),
        .validOut(validOut),
        .dataOut (dataOut)
`ifdef RADIX2_BUTTERFLY_LAST_EN
        ,
        .lastOut (lastOut)
`endif
    );

    always #5 clkIn = ~clkIn;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic val, input logic [W-1:0] d);
        enIn    = en;
        validIn = val;
        dataIn  = d;
        @(posedge clkIn);
        #1;
    endtask

    task automatic runPair(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W:0] expSum, input logic [W:0] expDiff);
        applyStimulus(1'b1, 1'b1, a);
        checkOutput({tag, "_aValid"}, validOut, 0);
        applyStimulus(1'b1, 1'b1, b);
        checkOutput({tag, "_sumValid"}, validOut, 1);
        checkOutput({tag, "_sum"}, dataOut, expSum);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput({tag, "_diffValid"}, validOut, 1);
        checkOutput({tag, "_diff"}, dataOut, expDiff);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput({tag, "_idleValid"}, validOut, 0);
    endtask

    // Reference model: pairs accepted samples, queues exact sum/diff, and checks every output beat.
    always begin
        @(posedge clkIn);
        if (!rstIn) begin
            sumQ.delete();
            diffQ.delete();
            modelPhaseB = 1'b0;
            heldA       = '0;
            edgeEnabled = 1'b0;
            lastData    = '0;
        end else begin
            edgeEnabled = enIn;
            if (enIn && validIn) begin
                acceptCount++;
                if (!modelPhaseB) begin
                    heldA       = dataIn;
                    modelPhaseB = 1'b1;
                end else begin
                    opA    = longint'($signed(heldA));
                    opB    = longint'($signed(dataIn));
                    result = opA + opB;
                    sumQ.push_back(result[W:0]);
                    result = opA - opB;
                    diffQ.push_back(result[W:0]);
                    modelPhaseB = 1'b0;
                end
            end
        end
        #2;
        expValid = edgeEnabled && ((sumQ.size() + diffQ.size()) != 0);
        checkOutput("modelValid", validOut, expValid);
        if (expValid) begin
            if (sumQ.size() != 0) begin
                expData   = sumQ.pop_front();
                expIsDiff = 1'b0;
            end else begin
                expData   = diffQ.pop_front();
                expIsDiff = 1'b1;
            end
            lastData = expData;
            if (validOut) begin
                checkOutput("modelData", dataOut, expData);
`ifdef RADIX2_BUTTERFLY_LAST_EN
                checkOutput("modelLast", lastOut, expIsDiff);
`endif
            end
        end else if (!validOut) begin
            checkOutput("modelHold", dataOut, lastData);
`ifdef RADIX2_BUTTERFLY_LAST_EN
            checkOutput("modelLastIdle", lastOut, 0);
`endif
        end
    end

    initial begin
        int startCount;
        int cycles;
        rstIn   = 1'b0;
        enIn    = 1'b1;
        validIn = 1'b0;
        dataIn  = '0;

        applyStimulus(1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("resetValid", validOut, 0);
        checkOutput("resetData", dataOut, 0);
        rstIn = 1'b1;
        applyStimulus(1'b1, 1'b0, '0);

        runPair("small", 32'd5, 32'd3, 33'h000000008, 33'h000000002);
        runPair("maxPos", 32'h7FFFFFFF, 32'h7FFFFFFF, 33'h0FFFFFFFE, 33'h000000000);
        runPair("minMax", 32'h80000000, 32'h7FFFFFFF, 33'h1FFFFFFFF, 33'h100000001);

        applyStimulus(1'b1, 1'b1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'hDEADBEEF);
            checkOutput("gapValid", validOut, 0);
        end
        applyStimulus(1'b1, 1'b1, 32'd2);
        checkOutput("gapSumValid", validOut, 1);
        checkOutput("gapSum", dataOut, 33'h000000003);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 32'd7);
            checkOutput("stallValid", validOut, 0);
            checkOutput("stallHold", dataOut, 33'h000000003);
        end
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("stallDiffValid", validOut, 1);
        checkOutput("stallDiff", dataOut, 33'h1FFFFFFFF);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("stallIdle", validOut, 0);

        applyStimulus(1'b1, 1'b1, 32'd9);
        rstIn = 1'b0;
        applyStimulus(1'b1, 1'b0, '0);
        rstIn = 1'b1;
        checkOutput("midResetValid", validOut, 0);
        checkOutput("midResetData", dataOut, 0);
        applyStimulus(1'b1, 1'b1, 32'd4);
        checkOutput("postResetA", validOut, 0);
        applyStimulus(1'b1, 1'b1, 32'd1);
        checkOutput("postResetSum", dataOut, 33'h000000005);
        applyStimulus(1'b1, 1'b0, '0);
        checkOutput("postResetDiff", dataOut, 33'h000000003);
        applyStimulus(1'b1, 1'b0, '0);

        startCount = acceptCount;
        cycles = 0;
        while ((acceptCount - startCount) < 1000 && cycles < 20000) begin
            applyStimulus(($urandom_range(0, 9) != 0), ($urandom_range(0, 9) < 7), $urandom);
            cycles++;
        end
        checkOutput("randomAccepts", acceptCount - startCount, 1000);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b0, '0);
        end
        checkOutput("drainSumQ", sumQ.size(), 0);
        checkOutput("drainDiffQ", diffQ.size(), 0);
        checkOutput("drainValid", validOut, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
